// File: rtl/wb_write_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, mul/div result handshake,
// the registered write port itself and the decode-side busy mask.
interface wb_write_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          pipe_we;
   logic [AW-1:0] pipe_waddr;
   logic [DW-1:0] pipe_wdata;

   logic          md_valid;
   logic          md_ready;
   logic [AW-1:0] md_waddr;
   logic [DW-1:0] md_wdata;

   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   logic [31:0]   busy_mask;

   modport master (
      output pipe_we, pipe_waddr, pipe_wdata,
      output md_valid, md_waddr, md_wdata,
      input  md_ready,
      input  rf_we, rf_waddr, rf_wdata,
      input  busy_mask
   );

   modport slave (
      input  pipe_we, pipe_waddr, pipe_wdata,
      input  md_valid, md_waddr, md_wdata,
      output md_ready,
      output rf_we, rf_waddr, rf_wdata,
      output busy_mask
   );
endinterface

// File: rtl/wb_write_arbiter.sv
// Single register-file write port shared by pipeline writeback (always wins) and the
// mul/div unit, whose displaced results wait in a small squashable FIFO.
module wb_write_arbiter #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                clk,
   input  logic                resetn,
   wb_write_arbiter_if.slave   bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [AW-1:0]    addr_d [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DW-1:0]    data_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic             rf_we_q, rf_we_d;
   logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
   logic [DW-1:0]    rf_wdata_q, rf_wdata_d;

   logic             md_ready;
   logic             md_xfer;
   logic             md_collide;
   logic             pop;
   logic             push;
   logic             bypass;
   logic [31:0]      busy_mask;

   assign md_ready   = resetn & (count_q < CW'(DEPTH));
   assign md_xfer    = bus.md_valid & md_ready;
   assign md_collide = bus.pipe_we & (bus.pipe_waddr == bus.md_waddr);

   // Output slot selection; addr/data hold when nothing is selected.
   always_comb begin
      pop        = 1'b0;
      bypass     = 1'b0;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (bus.pipe_we) begin
         rf_we_d    = |bus.pipe_waddr;
         rf_waddr_d = bus.pipe_waddr;
         rf_wdata_d = bus.pipe_wdata;
      end else if (count_q != '0) begin
         pop        = 1'b1;
         rf_we_d    = valid_q[rd_ptr_q];
         rf_waddr_d = addr_q[rd_ptr_q];
         rf_wdata_d = data_q[rd_ptr_q];
      end else if (md_xfer) begin
         bypass     = 1'b1;
         rf_we_d    = |bus.md_waddr;
         rf_waddr_d = bus.md_waddr;
         rf_wdata_d = bus.md_wdata;
      end
   end

   // r0 targets and results already overwritten by a same-cycle pipe write are dropped.
   assign push = md_xfer & ~bypass & (|bus.md_waddr) & ~md_collide;

   always_comb begin
      valid_d  = valid_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (bus.pipe_we && (addr_q[i] == bus.pipe_waddr)) begin
            valid_d[i] = 1'b0;
         end
      end

      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PW'(1);
      end

      if (push) begin
         valid_d[wr_ptr_q] = 1'b1;
         addr_d[wr_ptr_q]  = bus.md_waddr;
         data_d[wr_ptr_q]  = bus.md_wdata;
         wr_ptr_d          = wr_ptr_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Squashed entries drop out of the mask even though they still occupy a slot.
   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            busy_mask = busy_mask | (32'(1) << addr_q[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   assign bus.md_ready  = md_ready;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.busy_mask = busy_mask;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: a per-cycle vector table with hand-computed
// results, plus reset sequences around it.
module tb_wb_write_arbiter;

   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   wb_write_arbiter_if #(.AW(5), .DW(32)) bus_if ();

   wb_write_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   int total = 0;
   int bad   = 0;

   // One vector per clock: inputs driven before the edge, outputs expected after it.
   typedef struct {
      logic        pwe;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        mv;
      logic [4:0]  ma;
      logic [31:0] md;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] busy;
      logic        rdy;
      logic        chkAd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic pwe, logic [4:0] pa, logic [31:0] pd,
                               logic mv, logic [4:0] ma, logic [31:0] md,
                               logic we, logic [4:0] wa, logic [31:0] wd,
                               logic [31:0] busy, logic rdy, logic chkAd);
      vec_t v;
      v.pwe = pwe; v.pa = pa; v.pd = pd;
      v.mv = mv;   v.ma = ma; v.md = md;
      v.we = we;   v.wa = wa; v.wd = wd;
      v.busy = busy; v.rdy = rdy; v.chkAd = chkAd;
      return v;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md);
      bus_if.pipe_we    = pwe;
      bus_if.pipe_waddr = pa;
      bus_if.pipe_wdata = pd;
      bus_if.md_valid   = mv;
      bus_if.md_waddr   = ma;
      bus_if.md_wdata   = md;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      checkValue($sformatf("v%0d rf_we", idx), 32'(bus_if.rf_we), 32'(v.we));
      checkValue($sformatf("v%0d busy_mask", idx), bus_if.busy_mask, v.busy);
      checkValue($sformatf("v%0d md_ready", idx), 32'(bus_if.md_ready), 32'(v.rdy));
      if (v.chkAd) begin
         checkValue($sformatf("v%0d rf_waddr", idx), 32'(bus_if.rf_waddr), 32'(v.wa));
         checkValue($sformatf("v%0d rf_wdata", idx), bus_if.rf_wdata, v.wd);
      end
   endtask

   initial begin
      // pwe pa pd | mv ma md | we wa wd busy rdy chkAd
      vecs.push_back(mk(0, 0, 0,     1, 5, 32'h1234, 1, 5, 32'h1234, 32'h0,    1, 1)); // bypass
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 5, 32'h1234, 32'h0,    1, 1)); // hold
      vecs.push_back(mk(1, 3, 32'hA, 1, 7, 32'hB,    1, 3, 32'hA,    32'h80,   1, 1)); // collision
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,        1, 7, 32'hB,    32'h0,    1, 1));
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 7, 32'hB,    32'h0,    1, 1));
      vecs.push_back(mk(1, 1, 32'h11,1, 9, 32'h1,    1, 1, 32'h11,   32'h200,  1, 1)); // queue r9
      vecs.push_back(mk(1, 9, 32'h2, 0, 0, 0,        1, 9, 32'h2,    32'h0,    1, 1)); // squash r9
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 0, 0,        32'h0,    1, 0)); // squashed pop
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 0, 0,        32'h0,    1, 0));
      vecs.push_back(mk(1, 2, 32'h20,1, 10,32'hA0,   1, 2, 32'h20,   32'h400,  1, 1)); // fill
      vecs.push_back(mk(1, 3, 32'h30,1, 11,32'hB0,   1, 3, 32'h30,   32'hC00,  0, 1)); // full
      vecs.push_back(mk(1, 4, 32'h40,1, 12,32'hC0,   1, 4, 32'h40,   32'hC00,  0, 1)); // refused
      vecs.push_back(mk(0, 0, 0,     1, 12,32'hC0,   1, 10,32'hA0,   32'h800,  1, 1)); // first pop
      vecs.push_back(mk(0, 0, 0,     1, 12,32'hC0,   1, 11,32'hB0,   32'h1000, 1, 1)); // push+pop
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,        1, 12,32'hC0,   32'h0,    1, 1));
      vecs.push_back(mk(0, 0, 0,     1, 0, 32'h77,   0, 0, 0,        32'h0,    1, 0)); // md r0
      vecs.push_back(mk(1, 0, 32'h55,0, 0, 0,        0, 0, 0,        32'h0,    1, 0)); // pipe r0
      vecs.push_back(mk(1, 6, 32'h66,1, 6, 32'h99,   1, 6, 32'h66,   32'h0,    1, 1)); // same-reg drop
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 6, 32'h66,   32'h0,    1, 1));
      vecs.push_back(mk(1, 8, 32'h88,1, 0, 32'h1,    1, 8, 32'h88,   32'h0,    1, 1)); // md r0 vs pipe
      vecs.push_back(mk(0, 0, 0,     0, 0, 0,        0, 8, 32'h88,   32'h0,    1, 1));

      // Reset with a pending mul/div result
      resetn = 1'b0;
      applyStimulus(0, 0, 0, 1, 5, 32'hDEAD);
      repeat (2) @(negedge clk);
      checkValue("rst rf_we", 32'(bus_if.rf_we), 32'h0);
      checkValue("rst rf_waddr", 32'(bus_if.rf_waddr), 32'h0);
      checkValue("rst rf_wdata", bus_if.rf_wdata, 32'h0);
      checkValue("rst md_ready", 32'(bus_if.md_ready), 32'h0);
      checkValue("rst busy_mask", bus_if.busy_mask, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      resetn = 1'b1;
      #1;
      checkValue("post-rst md_ready", 32'(bus_if.md_ready), 32'h1);

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].mv, vecs[i].ma, vecs[i].md);
         @(posedge clk);
         #1;
         checkOutput(i, vecs[i]);
      end

      // Two queued entries, then an asynchronous reset pulse mid-cycle
      @(negedge clk);
      applyStimulus(1, 1, 32'h1, 1, 13, 32'hD0);
      @(negedge clk);
      applyStimulus(1, 2, 32'h2, 1, 14, 32'hE0);
      @(posedge clk);
      #1;
      checkValue("queued busy_mask", bus_if.busy_mask, 32'h6000);
      checkValue("queued md_ready", 32'(bus_if.md_ready), 32'h0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0);
      #2;
      resetn = 1'b0;
      #1;
      checkValue("midrst rf_we", 32'(bus_if.rf_we), 32'h0);
      checkValue("midrst rf_waddr", 32'(bus_if.rf_waddr), 32'h0);
      checkValue("midrst busy_mask", bus_if.busy_mask, 32'h0);
      checkValue("midrst md_ready", 32'(bus_if.md_ready), 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checkValue($sformatf("after-rst c%0d rf_we", c), 32'(bus_if.rf_we), 32'h0);
         checkValue($sformatf("after-rst c%0d busy_mask", c), bus_if.busy_mask, 32'h0);
         checkValue($sformatf("after-rst c%0d md_ready", c), 32'(bus_if.md_ready), 32'h1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
